// File: rtl/radar_capture_framer.sv
// Capture framer: aligns IQ samples, packs routable 32-bit lanes and frames each capture with header/trailer into an AXIS FIFO.
// Define CAPTURE_MIXER_EN to build the registered IQ mixer lane (route code 3) and its extra pipeline stage.
module radar_capture_framer #(
    parameter int NUM_LANES    = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int DDS_LATENCY  = 2,
    parameter int FIFO_DEPTH   = 512
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [SAMPLE_WIDTH-1:0]   adc_i,
    input  logic [SAMPLE_WIDTH-1:0]   adc_q,
    input  logic [SAMPLE_WIDTH-1:0]   dac_i,
    input  logic [SAMPLE_WIDTH-1:0]   dac_q,
    input  logic                      sample_valid,
    input  logic                      adc_enable,
    input  logic                      chirp_init,
    input  logic [2*NUM_LANES-1:0]    route_ctrl,
    output logic [32*NUM_LANES-1:0]   m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic                      overflow,
    output logic [15:0]               frame_count
);
    localparam int DW = 32 * NUM_LANES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = SAMPLE_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [3:0] LAT_C = 4'(DDS_LATENCY);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, DATA = 2'd2, DRAIN = 2'd3} state_t;

    state_t state;
    logic [3:0] lat_cnt;
    logic en_q;
    logic [63:0] timestamp, chirp_ts, hdr_ts;
    logic chirp_pending;
    logic [31:0] sample_count;
    logic [30:0] drop_count;
    logic frame_ovf;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, free;
    logic has_room, wr_en, wr_last, rd_en;
    logic [DW-1:0] wr_word, data_word, hdr_word, trl_word;
    logic [DW:0] mem [FIFO_DEPTH];
    logic [DW:0] rd_entry;
    logic [SW-1:0] s_adc_i, s_adc_q, s_dac_i, s_dac_q;
    logic s_valid, s_enable;

    function automatic logic [31:0] pack_iq(input logic [SW-1:0] hi, input logic [SW-1:0] lo);
        logic [31:0] w;
        w = '0;
        w[2*SW-1:0] = {hi, lo};
        return w;
    endfunction

`ifdef CAPTURE_MIXER_EN
    logic [SW-1:0] mix_i, mix_q;

    function automatic logic [SW-1:0] mix_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic signed [2*SW-1:0] p;
        p = $signed(a) * $signed(b);
        p = p >>> (SW - 1);
        return p[SW-1:0];
    endfunction

    // Whole sample path is delayed one cycle so the mixer product lines up with its raw samples.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_adc_i  <= '0;
            s_adc_q  <= '0;
            s_dac_i  <= '0;
            s_dac_q  <= '0;
            s_valid  <= 1'b0;
            s_enable <= 1'b0;
            mix_i    <= '0;
            mix_q    <= '0;
        end else begin
            s_adc_i  <= adc_i;
            s_adc_q  <= adc_q;
            s_dac_i  <= dac_i;
            s_dac_q  <= dac_q;
            s_valid  <= sample_valid;
            s_enable <= adc_enable;
            mix_i    <= mix_mul(adc_i, dac_i);
            mix_q    <= mix_mul(adc_q, dac_q);
        end
    end
`else
    assign s_adc_i  = adc_i;
    assign s_adc_q  = adc_q;
    assign s_dac_i  = dac_i;
    assign s_dac_q  = dac_q;
    assign s_valid  = sample_valid;
    assign s_enable = adc_enable;
`endif

    always_comb begin
        data_word = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            case (route_ctrl[2*k +: 2])
                2'd0:    data_word[32*k +: 32] = pack_iq(s_adc_i, s_adc_q);
                2'd1:    data_word[32*k +: 32] = pack_iq(s_dac_i, s_dac_q);
                2'd2:    data_word[32*k +: 32] = sample_count;
`ifdef CAPTURE_MIXER_EN
                default: data_word[32*k +: 32] = pack_iq(mix_i, mix_q);
`else
                default: data_word[32*k +: 32] = timestamp[31:0];
`endif
            endcase
        end
    end

    // The most recent chirp wins; without one the header carries the write-time stamp.
    always_comb begin
        hdr_ts = chirp_init ? timestamp : (chirp_pending ? chirp_ts : timestamp);
        hdr_word = '0;
        trl_word = '0;
        hdr_word[63:0]  = hdr_ts;
        trl_word[31:0]  = sample_count;
        trl_word[63:32] = {frame_ovf, drop_count};
        for (int k = 2; k < NUM_LANES; k++) begin
            hdr_word[32*k +: 32] = {16'hA5A5, frame_count};
            trl_word[32*k +: 32] = {16'h5A5A, frame_count};
        end
    end

    // One entry is always held back so a started frame can always be closed by its trailer.
    always_comb begin
        free     = DEPTH_C - count;
        has_room = free >= CW'(2);
        rd_en    = m_axis_tvalid && m_axis_tready;
        wr_en    = 1'b0;
        wr_last  = 1'b0;
        wr_word  = data_word;
        case (state)
            ARM: begin
                if (s_enable && lat_cnt == '0 && has_room) begin
                    wr_en   = 1'b1;
                    wr_word = hdr_word;
                end
            end
            DATA: wr_en = s_valid && has_room;
            DRAIN: begin
                if (lat_cnt == '0) begin
                    wr_en   = 1'b1;
                    wr_last = 1'b1;
                    wr_word = trl_word;
                end else begin
                    wr_en = s_valid && has_room;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            en_q          <= 1'b0;
            timestamp     <= '0;
            chirp_ts      <= '0;
            chirp_pending <= 1'b0;
            sample_count  <= '0;
            drop_count    <= '0;
            frame_ovf     <= 1'b0;
            overflow      <= 1'b0;
            frame_count   <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            timestamp <= timestamp + 64'd1;
            en_q      <= s_enable;
            if (chirp_init) begin
                chirp_ts      <= timestamp;
                chirp_pending <= 1'b1;
            end
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);

            if ((state == DATA || (state == DRAIN && lat_cnt != '0)) && s_valid) begin
                sample_count <= sample_count + 32'd1;
                if (!has_room) begin
                    frame_ovf <= 1'b1;
                    overflow  <= 1'b1;
                    if (drop_count != '1) drop_count <= drop_count + 31'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (s_enable) begin
                        state   <= ARM;
                        lat_cnt <= LAT_C;
                    end
                end
                ARM: begin
                    if (!s_enable) begin
                        state <= IDLE;
                    end else if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else if (has_room) begin
                        state         <= DATA;
                        sample_count  <= '0;
                        drop_count    <= '0;
                        frame_ovf     <= 1'b0;
                        chirp_pending <= 1'b0;
                    end else begin
                        overflow <= 1'b1;
                        state    <= IDLE;
                    end
                end
                // Falling edge taken from the registered enable so the last enabled sample cycle is kept.
                DATA: begin
                    if (!en_q) begin
                        state   <= DRAIN;
                        lat_cnt <= LAT_C;
                    end
                end
                DRAIN: begin
                    if (lat_cnt == '0) begin
                        state       <= IDLE;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= {wr_last, wr_word};
    end

    assign rd_entry      = mem[rd_ptr];
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? rd_entry[DW-1:0] : '0;
    assign m_axis_tlast  = m_axis_tvalid ? rd_entry[DW] : 1'b0;

endmodule
